cdb_forward_buffer: RTL and testbench

Multi-port, multi-CDB operand forwarding buffer for the RAT+physical-register core. It holds a DEPTH-cycle history of every valid CDB broadcast, and answers NUM_REQ parallel physical-tag lookups against the live CDBs and that history. Stale entries are killed on pipeline flush and when the free list re-allocates a physical tag. It sits between the CDB arbiter and issue/operand-read, and replaces the single-CDB, one-cycle-history forwarder.

---
 rtl/cdb_forward_buffer.sv | 105 ++++++++++
 tb/tb_cdb_forward_buffer.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/cdb_forward_buffer.sv
// cdb_forward_buffer: multi-CDB operand forwarder with a DEPTH-stage broadcast history
// Optional FWD_DUP_CHECK_EN: sticky dup_err when two valid CDB ports carry the same tag.
module cdb_forward_buffer #(
    parameter int XLEN    = 32,
    parameter int TAG_W   = 6,
    parameter int NUM_CDB = 2,
    parameter int NUM_REQ = 4,
    parameter int DEPTH   = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_CDB-1:0]                    cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0]              cdb_tag,
    input  logic [NUM_CDB*XLEN-1:0]               cdb_result,
    input  logic                                  flush,
    input  logic                                  alloc_valid,
    input  logic [TAG_W-1:0]                      alloc_tag,
    input  logic [NUM_REQ*TAG_W-1:0]              req_tag,
    output logic [NUM_REQ-1:0]                    fwd_hit,
    output logic [NUM_REQ*XLEN-1:0]               fwd_data,
    output logic [NUM_REQ*$clog2(DEPTH+1)-1:0]    fwd_age,
    output logic                                  dup_err
);
    localparam int AGE_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][NUM_CDB-1:0]            vld_q, vld_d;
    logic [DEPTH-1:0][NUM_CDB-1:0][TAG_W-1:0] tag_q, tag_d;
    logic [DEPTH-1:0][NUM_CDB-1:0][XLEN-1:0]  dat_q, dat_d;

    // Shift history one stage; flush kills everything, alloc kills matching shifted entries
    always_comb begin
        for (int i = 0; i < NUM_CDB; i++) begin
            vld_d[0][i] = cdb_valid[i] & ~flush;
            tag_d[0][i] = cdb_tag[i*TAG_W +: TAG_W];
            dat_d[0][i] = cdb_result[i*XLEN +: XLEN];
            for (int k = 1; k < DEPTH; k++) begin
                vld_d[k][i] = vld_q[k-1][i] & ~flush & ~(alloc_valid && tag_q[k-1][i] == alloc_tag);
                tag_d[k][i] = tag_q[k-1][i];
                dat_d[k][i] = dat_q[k-1][i];
            end
        end
    end

    // History registers with synchronous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            tag_q <= '0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            tag_q <= tag_d;
            dat_q <= dat_d;
        end
    end

    // Lookup: scan lowest priority first so the highest-priority match is written last
    always_comb begin
        fwd_hit  = '0;
        fwd_data = '0;
        fwd_age  = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            for (int k = DEPTH - 1; k >= 0; k--) begin
                for (int i = NUM_CDB - 1; i >= 0; i--) begin
                    if (vld_q[k][i] && tag_q[k][i] == req_tag[r*TAG_W +: TAG_W]) begin
                        fwd_hit[r]                 = 1'b1;
                        fwd_data[r*XLEN +: XLEN]   = dat_q[k][i];
                        fwd_age[r*AGE_W +: AGE_W]  = AGE_W'(k + 1);
                    end
                end
            end
            for (int i = NUM_CDB - 1; i >= 0; i--) begin
                if (cdb_valid[i] && cdb_tag[i*TAG_W +: TAG_W] == req_tag[r*TAG_W +: TAG_W]) begin
                    fwd_hit[r]                 = 1'b1;
                    fwd_data[r*XLEN +: XLEN]   = cdb_result[i*XLEN +: XLEN];
                    fwd_age[r*AGE_W +: AGE_W]  = '0;
                end
            end
        end
    end

`ifdef FWD_DUP_CHECK_EN
    logic dup_now;
    logic dup_q;

    // Pairwise compare of valid live CDB tags
    always_comb begin
        dup_now = 1'b0;
        for (int i = 0; i < NUM_CDB; i++)
            for (int j = i + 1; j < NUM_CDB; j++)
                if (cdb_valid[i] && cdb_valid[j] && cdb_tag[i*TAG_W +: TAG_W] == cdb_tag[j*TAG_W +: TAG_W])
                    dup_now = 1'b1;
    end

    // Sticky error flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) dup_q <= 1'b0;
        else if (dup_now) dup_q <= 1'b1;
    end

    assign dup_err = dup_q;
`else
    assign dup_err = 1'b0;
`endif
endmodule

// File: tb/tb_cdb_forward_buffer.sv
// tb_cdb_forward_buffer: directed checks of live/history forwarding, alloc kill, flush, dup flag
module tb_cdb_forward_buffer;
    logic        clk = 0;
    logic        rst = 1;
    logic [1:0]  cdb_valid = '0;
    logic [11:0] cdb_tag = '0;
    logic [63:0] cdb_result = '0;
    logic        flush = 0;
    logic        alloc_valid = 0;
    logic [5:0]  alloc_tag = '0;
    logic [23:0] req_tag = '0;
    logic [3:0]  fwd_hit;
    logic [127:0] fwd_data;
    logic [11:0] fwd_age;
    logic        dup_err;
    int total = 0;
    int bad = 0;
`ifdef FWD_DUP_CHECK_EN
    localparam logic DUP_EXP = 1'b1;
`else
    localparam logic DUP_EXP = 1'b0;
`endif

    cdb_forward_buffer dut (
        .clk(clk), .rst(rst), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_result(cdb_result),
        .flush(flush), .alloc_valid(alloc_valid), .alloc_tag(alloc_tag), .req_tag(req_tag),
        .fwd_hit(fwd_hit), .fwd_data(fwd_data), .fwd_age(fwd_age), .dup_err(dup_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string t, input logic [63:0] o, input logic [63:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", t, o, e);
        end
    endtask

    initial begin
        tick();
        tick();
        rst = 0;
        #1;
        chk("rst_hit", 64'(fwd_hit), 64'h0);
        chk("rst_data", 64'(fwd_data[31:0]), 64'h0);
        chk("rst_age", 64'(fwd_age[2:0]), 64'h0);
        chk("rst_dup", 64'(dup_err), 64'h0);
        // single broadcast aging through all stages
        cdb_valid = 2'b01; cdb_tag = {6'd0, 6'd5}; cdb_result = {32'h0, 32'hDEAD_BEEF};
        req_tag[5:0] = 6'd5;
        #1;
        chk("age0_hit", 64'(fwd_hit[0]), 64'h1);
        chk("age0_data", 64'(fwd_data[31:0]), 64'hDEAD_BEEF);
        chk("age0_age", 64'(fwd_age[2:0]), 64'h0);
        tick();
        cdb_valid = 2'b00;
        #1;
        chk("age1_hit", 64'(fwd_hit[0]), 64'h1);
        chk("age1_age", 64'(fwd_age[2:0]), 64'h1);
        tick();
        chk("age2_age", 64'(fwd_age[2:0]), 64'h2);
        chk("age2_data", 64'(fwd_data[31:0]), 64'hDEAD_BEEF);
        tick();
        chk("age3_age", 64'(fwd_age[2:0]), 64'h3);
        tick();
        chk("age4_hit", 64'(fwd_hit[0]), 64'h1);
        chk("age4_age", 64'(fwd_age[2:0]), 64'h4);
        tick();
        chk("age5_hit", 64'(fwd_hit[0]), 64'h0);
        chk("age5_data", 64'(fwd_data[31:0]), 64'h0);
        chk("age5_age", 64'(fwd_age[2:0]), 64'h0);
        // live beats history, newer stage beats older
        cdb_valid = 2'b01; cdb_tag = {6'd0, 6'd9}; cdb_result = {32'h0, 32'h11};
        tick();
        cdb_valid = 2'b10; cdb_tag = {6'd9, 6'd0}; cdb_result = {32'h22, 32'h0};
        req_tag[5:0] = 6'd9;
        #1;
        chk("pri_live_data", 64'(fwd_data[31:0]), 64'h22);
        chk("pri_live_age", 64'(fwd_age[2:0]), 64'h0);
        tick();
        cdb_valid = 2'b00;
        #1;
        chk("pri_hist_data", 64'(fwd_data[31:0]), 64'h22);
        chk("pri_hist_age", 64'(fwd_age[2:0]), 64'h1);
        // alloc kills stale tag on the following edge
        cdb_valid = 2'b01; cdb_tag = {6'd0, 6'd3}; cdb_result = {32'h0, 32'h33};
        req_tag[5:0] = 6'd3;
        tick();
        cdb_valid = 2'b00; alloc_valid = 1; alloc_tag = 6'd3;
        #1;
        chk("alloc_cyc_hit", 64'(fwd_hit[0]), 64'h1);
        chk("alloc_cyc_age", 64'(fwd_age[2:0]), 64'h1);
        chk("alloc_cyc_data", 64'(fwd_data[31:0]), 64'h33);
        tick();
        alloc_valid = 0;
        #1;
        chk("alloc_after_hit", 64'(fwd_hit[0]), 64'h0);
        // flush: live still matches, everything gone next cycle
        cdb_valid = 2'b01; cdb_tag = {6'd0, 6'd7}; cdb_result = {32'h0, 32'h77};
        req_tag[11:0] = {6'd8, 6'd7};
        tick();
        cdb_valid = 2'b10; cdb_tag = {6'd8, 6'd0}; cdb_result = {32'h88, 32'h0}; flush = 1;
        #1;
        chk("flush_cyc_hit", 64'(fwd_hit[1:0]), 64'h3);
        chk("flush_cyc_age0", 64'(fwd_age[2:0]), 64'h1);
        chk("flush_cyc_data1", 64'(fwd_data[63:32]), 64'h88);
        tick();
        flush = 0; cdb_valid = 2'b00;
        #1;
        chk("flush_after_hit", 64'(fwd_hit[1:0]), 64'h0);
        // duplicate tags on both ports
        cdb_valid = 2'b11; cdb_tag = {6'd12, 6'd12}; cdb_result = {32'hB, 32'hA};
        req_tag[5:0] = 6'd12;
        #1;
        chk("dup_data", 64'(fwd_data[31:0]), 64'hA);
        chk("dup_pre", 64'(dup_err), 64'h0);
        tick();
        cdb_valid = 2'b00;
        #1;
        chk("dup_set", 64'(dup_err), 64'(DUP_EXP));
        chk("dup_hist_data", 64'(fwd_data[31:0]), 64'hA);
        tick();
        chk("dup_sticky", 64'(dup_err), 64'(DUP_EXP));
        // four parallel requests
        flush = 1;
        tick();
        flush = 0;
        cdb_valid = 2'b11; cdb_tag = {6'd2, 6'd1}; cdb_result = {32'h200, 32'h100};
        req_tag = {6'd63, 6'd1, 6'd2, 6'd1};
        #1;
        chk("multi_hit", 64'(fwd_hit), 64'h7);
        chk("multi_d0", 64'(fwd_data[31:0]), 64'h100);
        chk("multi_d1", 64'(fwd_data[63:32]), 64'h200);
        chk("multi_d2", 64'(fwd_data[95:64]), 64'h100);
        chk("multi_d3", 64'(fwd_data[127:96]), 64'h0);
        // reset mid-operation drops history and the live CDB
        cdb_tag = {6'd21, 6'd20}; rst = 1;
        tick();
        rst = 0; cdb_valid = 2'b00; req_tag = {6'd0, 6'd0, 6'd21, 6'd20};
        #1;
        chk("rst_mid_hit", 64'(fwd_hit), 64'h0);
        chk("rst_mid_dup", 64'(dup_err), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
